// File: rtl/mem_access_unit.sv
// Memory access sequencer for the multicycle core: one load or store per start pulse.
// Sub-word stores read-modify-write; loads return a sign-extended result for write-back.
module mem_access_unit #(
  parameter int unsigned MEM_LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned CNT_W = 4;
  localparam logic [1:0]  SZ_WORD = 2'd0;
  localparam logic [1:0]  SZ_BYTE = 2'd1;
  localparam logic [1:0]  SZ_HALF = 2'd2;
  localparam logic [1:0]  SZ_BAD  = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               store_q, store_d;
  logic [1:0]         size_q, size_d;
  logic [1:0]         off_q, off_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               mem_wr_q, mem_wr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               req_bad;

  // Big-endian lane select: byte 0 is bits [31:24], half 0 is bits [31:16].
  function automatic logic [31:0] load_ext(input logic [1:0] sz, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    case (sz)
      SZ_BYTE: r = {{24{b[7]}}, b};
      SZ_HALF: r = {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_word(input logic [1:0] sz, input logic [1:0] off,
                                             input logic [31:0] w, input logic [31:0] d);
    logic [31:0] r;
    r = w;
    if (sz == SZ_BYTE) begin
      case (off)
        2'd0:    r[31:24] = d[7:0];
        2'd1:    r[23:16] = d[7:0];
        2'd2:    r[15:8]  = d[7:0];
        default: r[7:0]   = d[7:0];
      endcase
    end else if (off[1]) begin
      r[15:0] = d[15:0];
    end else begin
      r[31:16] = d[15:0];
    end
    return r;
  endfunction

  assign req_bad = (size == SZ_BAD) ||
                   ((size == SZ_HALF) && addr[0]) ||
                   ((size == SZ_WORD) && (addr[1:0] != 2'b00));

  // Next-state and registered-output decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    store_d     = store_q;
    size_d      = size_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    err_d       = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          store_d    = is_store;
          size_d     = size;
          off_d      = addr[1:0];
          wdata_d    = wdata;
          mem_addr_d = {addr[31:2], 2'b00};
          if (req_bad) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else if (is_store && (size == SZ_WORD)) begin
            state_d     = WRITE;
            mem_wdata_d = wdata;
          end else begin
            state_d = RD_WAIT;
            cnt_d   = CNT_W'(MEM_LATENCY);
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD_WAIT: begin
        // Sub-word merge is folded into the capture edge so the write issues next cycle.
        if (cnt_q == '0) begin
          if (store_q) begin
            state_d     = WRITE;
            mem_wdata_d = merge_word(size_q, off_q, mem_rdata, wdata_q);
          end else begin
            state_d = DONE;
            rdata_d = load_ext(size_q, off_q, mem_rdata);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WRITE:   state_d = DONE;
      default: state_d = IDLE;
    endcase

    busy_d   = (state_d == RD_WAIT) || (state_d == WRITE);
    done_d   = (state_d == DONE);
    mem_wr_d = (state_d == WRITE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      store_q     <= 1'b0;
      size_q      <= 2'b00;
      off_q       <= 2'b00;
      wdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      mem_wr_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      store_q     <= store_d;
      size_q      <= size_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      mem_wr_q    <= mem_wr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wr    = mem_wr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
